// File: rtl/seg_add_sub_pkg.sv
// Shared definitions for the sequential ALU blocks: FSM state encodings
// and a counter-width helper that stays legal when only one segment exists.
package seg_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } segState_t;

    function automatic int cntWidth(input int nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

endpackage

// File: rtl/seg_add_sub_slice.sv
// SLICE-bit combinational ripple adder built from single-bit full adders.
// Latency 0 (pure combinational); no flow control.
// Also exposes the carry into the slice MSB so the caller can derive signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_sub_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] sum,
    output logic             co,
    output logic             cMsb
);
    logic [SLICE:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE; i++) begin : gBit
        full_adder uFa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign co   = c[SLICE];
    assign cMsb = c[SLICE-1];
endmodule

// File: rtl/seg_add_sub.sv
// Segmented WIDTH-bit add/subtract, SLICE bits per clock, LSB slice first.
// Latency NSEG cycles from accepted START to DONE; results registered.
// START is ignored while BUSY; a START during the DONE cycle is accepted.
module seg_add_sub
    import seg_add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SnA,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             OV,
    output logic             ZF
);
    localparam int NSEG = WIDTH / SLICE;
    localparam int CW   = cntWidth(NSEG);
    localparam logic [CW-1:0] LAST = CW'(NSEG - 1);

    segState_t        state;
    logic [CW-1:0]    segCnt;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] partial;
    logic             carry;

    logic [SLICE-1:0] aSeg;
    logic [SLICE-1:0] bSeg;
    logic [SLICE-1:0] sumSeg;
    logic             sliceCo;
    logic             sliceCMsb;
    logic [WIDTH-1:0] partialNext;

    // Segment select kept apart from the write-back merge so the ripple is not a comb loop.
    always_comb begin
        aSeg = '0;
        bSeg = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (segCnt == CW'(k)) begin
                aSeg = opA[k*SLICE +: SLICE];
                bSeg = opB[k*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        partialNext = partial;
        for (int k = 0; k < NSEG; k++) begin
            if (segCnt == CW'(k)) begin
                partialNext[k*SLICE +: SLICE] = sumSeg;
            end
        end
    end

    add_sub_slice #(.SLICE(SLICE)) uSlice (
        .a    (aSeg),
        .b    (bSeg),
        .ci   (carry),
        .sum  (sumSeg),
        .co   (sliceCo),
        .cMsb (sliceCMsb)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            segCnt  <= '0;
            opA     <= '0;
            opB     <= '0;
            partial <= '0;
            carry   <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            Y       <= '0;
            CO      <= 1'b0;
            OV      <= 1'b0;
            ZF      <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        // Subtract is A + ~B + 1: invert B once here, inject the +1 as carry-in.
                        opA     <= A;
                        opB     <= B ^ {WIDTH{SnA}};
                        carry   <= SnA;
                        segCnt  <= '0;
                        partial <= '0;
                        BUSY    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    partial <= partialNext;
                    carry   <= sliceCo;
                    segCnt  <= segCnt + CW'(1);
                    if (segCnt == LAST) begin
                        Y      <= partialNext;
                        CO     <= sliceCo;
                        OV     <= sliceCMsb ^ sliceCo;
                        ZF     <= (partialNext == '0);
                        segCnt <= '0;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        state  <= FIN;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seg_add_sub.sv
// Bench for seg_add_sub: 32/8 and 64/16 instances share stimulus and are
// checked every cycle against a countdown-and-arithmetic reference model.
module tb_seg_add_sub;
    localparam int NSEG = 4;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        SnA;
    logic [63:0] A;
    logic [63:0] B;

    logic        busy32, done32, co32, ov32, zf32;
    logic [31:0] y32;
    logic        busy64, done64, co64, ov64, zf64;
    logic [63:0] y64;

    int compared   = 0;
    int mismatched = 0;
    bit cmpOn      = 0;

    seg_add_sub #(.WIDTH(32), .SLICE(8)) dut32 (
        .CLK(CLK), .RST(RST), .START(START), .SnA(SnA), .A(A[31:0]), .B(B[31:0]),
        .BUSY(busy32), .DONE(done32), .Y(y32), .CO(co32), .OV(ov32), .ZF(zf32)
    );

    seg_add_sub #(.WIDTH(64), .SLICE(16)) dut64 (
        .CLK(CLK), .RST(RST), .START(START), .SnA(SnA), .A(A), .B(B),
        .BUSY(busy64), .DONE(done64), .Y(y64), .CO(co64), .OV(ov64), .ZF(zf64)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Result packing: [66]=CO, [65]=OV, [64]=ZF, [63:0]=Y.
    function automatic logic [66:0] calc(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input logic s);
        logic [63:0] mask, aa, bb, y;
        logic [64:0] full;
        logic co, ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa   = a & mask;
        bb   = (s ? ~b : b) & mask;
        full = {1'b0, aa} + {1'b0, bb} + 65'(s);
        y    = full[63:0] & mask;
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (y[w-1] != aa[w-1]);
        return {co, ov, (y == 64'd0), y};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request counts down NSEG edges, then commits.
    int          busyLeft[2];
    logic        mDone[2];
    logic [66:0] res[2];
    logic [66:0] pend[2];
    int          W[2] = '{32, 64};
    logic        dn;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 2; i++) begin
                busyLeft[i] = 0;
                mDone[i]    = 1'b0;
                res[i]      = '0;
                pend[i]     = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                dn = 1'b0;
                if (busyLeft[i] > 0) begin
                    busyLeft[i]--;
                    if (busyLeft[i] == 0) begin
                        res[i] = pend[i];
                        dn     = 1'b1;
                    end
                end else if (START) begin
                    pend[i]     = calc(W[i], A, B, SnA);
                    busyLeft[i] = NSEG;
                end
                mDone[i] = dn;
            end
        end
    end

    always @(negedge CLK) begin
        if (cmpOn) begin
            chk("busy32", 64'(busy32), 64'(busyLeft[0] > 0));
            chk("done32", 64'(done32), 64'(mDone[0]));
            chk("y32",    {32'd0, y32}, res[0][63:0]);
            chk("co32",   64'(co32),   64'(res[0][66]));
            chk("ov32",   64'(ov32),   64'(res[0][65]));
            chk("zf32",   64'(zf32),   64'(res[0][64]));
            chk("busy64", 64'(busy64), 64'(busyLeft[1] > 0));
            chk("done64", 64'(done64), 64'(mDone[1]));
            chk("y64",    y64,         res[1][63:0]);
            chk("co64",   64'(co64),   64'(res[1][66]));
            chk("ov64",   64'(ov64),   64'(res[1][65]));
            chk("zf64",   64'(zf64),   64'(res[1][64]));
        end
    end

    task automatic doOp(input logic [63:0] a, input logic [63:0] b, input logic s);
        @(negedge CLK);
        A = a; B = b; SnA = s; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic waitDone(output int busyCnt);
        busyCnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (done32) return;
            if (busy32) busyCnt++;
            @(negedge CLK);
        end
        compared++;
        mismatched++;
        $display("FAIL wait_done: no DONE within 30 cycles, busy seen %0d", busyCnt);
    endtask

    task automatic chk32(input string nm, input logic [31:0] y, input logic co,
                         input logic ov, input logic zf);
        chk({nm, "_y"},  {32'd0, y32}, {32'd0, y});
        chk({nm, "_co"}, 64'(co32), 64'(co));
        chk({nm, "_ov"}, 64'(ov32), 64'(ov));
        chk({nm, "_zf"}, 64'(zf32), 64'(zf));
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'h0;
            1:       return '1;
            2:       return 64'h8000_0000_8000_0000;
            3:       return 64'h7FFF_FFFF_7FFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [66:0] r;
    int          bc;
    int          dc;

    initial begin
        RST = 1'b0; START = 1'b0; SnA = 1'b0; A = '0; B = '0;

        r = calc(32, 64'h5, 64'h3, 1'b0);
        chk("model_add", 64'(r), {3'b000, 64'h8});
        r = calc(32, 64'h3, 64'h5, 1'b1);
        chk("model_sub", 64'(r[66:64]), 64'(3'b000));
        chk("model_sub_y", r[63:0], 64'hFFFF_FFFE);
        r = calc(64, '1, 64'h1, 1'b0);
        chk("model_wrap64", 64'(r[66:64]), 64'(3'b101));

        repeat (3) @(negedge CLK);
        chk("rst_busy", 64'(busy32 | busy64), 64'd0);
        chk("rst_done", 64'(done32 | done64), 64'd0);
        chk("rst_y",    y64 | {32'd0, y32}, 64'd0);
        chk("rst_flags", 64'({co32, ov32, zf32, co64, ov64, zf64}), 64'd0);
        RST = 1'b1;
        cmpOn = 1'b1;

        doOp(64'h5, 64'h3, 1'b0);
        waitDone(bc);
        chk("t1_busy_cycles", 64'(bc), 64'd4);
        chk32("t1", 32'h8, 1'b0, 1'b0, 1'b0);

        doOp(64'h3, 64'h5, 1'b1);
        waitDone(bc);
        chk32("t2", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        doOp(64'h7FFF_FFFF, 64'h1, 1'b0);
        waitDone(bc);
        chk32("t3", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        doOp(64'h8000_0000, 64'h1, 1'b1);
        waitDone(bc);
        chk32("t4", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        doOp(64'h1234_5678, 64'h1234_5678, 1'b1);
        waitDone(bc);
        chk32("t5", 32'h0, 1'b1, 1'b0, 1'b1);
        // START driven during the FIN cycle must be taken.
        A = 64'h1; B = 64'h1; SnA = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        waitDone(bc);
        chk("t5b_busy_cycles", 64'(bc), 64'd4);
        chk32("t5b", 32'h2, 1'b0, 1'b0, 1'b0);

        doOp(64'd100, 64'd23, 1'b0);
        A = 64'd999; B = 64'd1; SnA = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        waitDone(bc);
        chk32("t6", 32'd123, 1'b0, 1'b0, 1'b0);
        dc = 0;
        repeat (10) begin
            @(negedge CLK);
            if (done32) dc++;
        end
        chk("t6_extra_done", 64'(dc), 64'd0);

        doOp('1, 64'h1, 1'b0);
        waitDone(bc);
        chk("t7_busy_cycles", 64'(bc), 64'd4);
        chk("t7_y64", y64, 64'd0);
        chk("t7_flags64", 64'({co64, ov64, zf64}), 64'(3'b101));
        chk32("t7", 32'h0, 1'b1, 1'b0, 1'b1);

        doOp(64'd9, 64'd9, 1'b0);
        waitDone(bc);
        chk32("t8pre", 32'd18, 1'b0, 1'b0, 1'b0);
        doOp(64'd1, 64'd2, 1'b0);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("t8_busy", 64'(busy32 | busy64), 64'd0);
        chk("t8_done", 64'(done32 | done64), 64'd0);
        chk("t8_y",    y64 | {32'd0, y32}, 64'd0);
        chk("t8_flags", 64'({co32, ov32, zf32, co64, ov64, zf64}), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        dc = 0;
        repeat (10) begin
            @(negedge CLK);
            if (done32 || done64) dc++;
        end
        chk("t8_no_done", 64'(dc), 64'd0);

        repeat (1500) begin
            @(negedge CLK);
            START = ($urandom_range(0, 3) == 0);
            A = pick(); B = pick(); SnA = 1'($urandom_range(0, 1));
        end
        repeat (100) begin
            @(negedge CLK);
            START = 1'b1;
            A = pick(); B = pick(); SnA = 1'($urandom_range(0, 1));
        end
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
